rename_ckpt_unit: RTL and testbench
===================================

// Module: rename_ckpt_unit
// PURPOSE
//   Parametrised register-rename unit for the OoO mips_core: logical->physical map table, circular
//   free-list FIFO, per-physical ready bits and producer ROB tags, plus a ring of NUM_CKPT map
//   checkpoints for multiple unresolved branches. Sits between decode and issue; the ROB drives
//   commit frees; branch resolution drives checkpoint release and recovery.
// PARAMETERS
//   NUM_LOG      32  logical registers; reg 0 hardwired to phys 0, never renamed
//   NUM_PHYS     64  physical registers; free-list depth FL_D = NUM_PHYS-NUM_LOG
//   NUM_CKPT     4   checkpoint slots, allocated and resolved in program order
//   ROB_TAG_W    4   ROB tag width
// PORTS
//   clk              in   1          clock
//   rst              in   1          synchronous reset, active-high
//   ren_valid        in   1          decoded instruction presented for rename
//   ren_ready        out  1          rename accepted this cycle (stall when 0)
//   rs_addr,rt_addr  in   log2(L)    source logical regs
//   rw_addr          in   log2(L)    destination logical reg
//   uses_rw          in   1          instruction writes rw_addr
//   ren_rob_tag      in   ROB_TAG_W  ROB tag of the renamed instruction
//   ckpt_take        in   1          instruction is a branch; snapshot after its rename
//   rs_phy,rt_phy    out  log2(P)    source physical regs
//   rs_ready,rt_ready out 1          source value available
//   rs_tag,rt_tag    out  ROB_TAG_W  producer ROB tag when not ready
//   rw_phy           out  log2(P)    allocated phys reg (0 when none)
//   rw_old_phy       out  log2(P)    previous mapping of rw_addr, stored in ROB for commit free
//   wb_en, wb_phy    in   1, log2(P) writeback: set ready[wb_phy]
//   cmt_en, cmt_old_phy in 1, log2(P) commit: push cmt_old_phy to free list
//   res_en           in   1          oldest checkpointed branch resolved
//   res_mispredict   in   1          with res_en: restore oldest checkpoint
//   ckpt_cnt         out  log2(C)+1  live checkpoints
//   fl_cnt           out  log2(FL_D)+1 free-list occupancy
// BEHAVIOUR
//   Reset: map[i]=i; ready all 1; tags 0; free list holds NUM_LOG..NUM_PHYS-1 in order,
//     head=tail=0 with wrap bits differing (full), fl_cnt=FL_D; ckpt ring empty, ckpt_cnt=0.
//   Lookups combinational from current map. Bypass: wb_en on a source's phys in same cycle
//     -> that ready output is 1. rs/rt addr 0 -> phys 0, ready 1.
//   ren_ready = !(needs_alloc && fl_cnt==0) && !(ckpt_take && ckpt_cnt==NUM_CKPT) && !recover,
//     where needs_alloc = uses_rw && rw_addr!=0. Fire = ren_valid && ren_ready.
//   On fire with needs_alloc: rw_phy = free[head]; head++; map[rw_addr]<=rw_phy;
//     ready[rw_phy]<=0; tag[rw_phy]<=ren_rob_tag. No alloc -> rw_phy=0, map unchanged.
//   rw_addr==rs/rt_addr: sources read OLD mapping (combinational, pre-update).
//   On fire with ckpt_take: slot[ckpt_tail] <= {map incl. this cycle's update, head incl. pop}.
//   cmt_en: free[tail]<=cmt_old_phy; tail++ (cmt_old_phy==0 ignored). Push and pop same
//     cycle both apply; push into a full list is illegal (assertion).
//   wb_en: ready[wb_phy]<=1; same-cycle alloc of same phys: alloc wins (ready<=0).
//   res_en && !res_mispredict: pop oldest checkpoint (ckpt_head++).
//   res_en && res_mispredict (recover): map<=slot[ckpt_head].map; head<=slot.head; all
//     checkpoints cleared; rename blocked this cycle. Tail keeps advancing for same-cycle
//     cmt_en. Ready/tag arrays not restored (squashed regs are re-cleared on reallocation).
//   fl_cnt = tail-head with wrap bit; ckpt_cnt likewise. Pointers wrap at FL_D / NUM_CKPT.
//   res_en with ckpt_cnt==0: ignored (assertion). rst mid-operation returns to reset state next cycle.
// TESTING
//   Reset, rename rw=5 -> rw_phy=32, rw_old_phy=5; next rs=5 -> rs_phy=32, rs_ready=0.
//   32 allocs, no commits -> fl_cnt=0, ren_ready=0 on alloc, 1 for rw=0 insts; cmt_en phys 5 -> ren_ready=1, next rw_phy=5.
//   wb_en phys 32 same cycle as rs=5 lookup -> rs_ready=1; following cycle ready held.
//   ckpt after rw=3->33; rename rw=3->34, rw=7->35; mispredict -> map[3]=33, map[7]=7, next alloc=34.
//   Take 4 ckpts -> ckpt_take stalls; res_en correct -> ckpt_cnt=3, stall clears.
//   Recover with simultaneous cmt_en(phys 9) -> fl_cnt = restored count +1, phys 9 later allocated.

Source files
------------

// File: rtl/rename_ckpt_unit.sv
// Register-rename unit: map table, circular free list, ready/tag scoreboard and a
// ring of map checkpoints so that mispredicted branches can be recovered in one cycle.
module rename_ckpt_unit #(
  parameter int NUM_LOG   = 32,
  parameter int NUM_PHYS  = 64,
  parameter int NUM_CKPT  = 4,
  parameter int ROB_TAG_W = 4,
  localparam int LW   = $clog2(NUM_LOG),
  localparam int PW   = $clog2(NUM_PHYS),
  localparam int FL_D = NUM_PHYS - NUM_LOG,
  localparam int FW   = $clog2(FL_D),
  localparam int CW   = $clog2(NUM_CKPT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ren_valid,
  output logic                 ren_ready,
  input  logic [LW-1:0]        rs_addr,
  input  logic [LW-1:0]        rt_addr,
  input  logic [LW-1:0]        rw_addr,
  input  logic                 uses_rw,
  input  logic [ROB_TAG_W-1:0] ren_rob_tag,
  input  logic                 ckpt_take,
  output logic [PW-1:0]        rs_phy,
  output logic [PW-1:0]        rt_phy,
  output logic                 rs_ready,
  output logic                 rt_ready,
  output logic [ROB_TAG_W-1:0] rs_tag,
  output logic [ROB_TAG_W-1:0] rt_tag,
  output logic [PW-1:0]        rw_phy,
  output logic [PW-1:0]        rw_old_phy,
  input  logic                 wb_en,
  input  logic [PW-1:0]        wb_phy,
  input  logic                 cmt_en,
  input  logic [PW-1:0]        cmt_old_phy,
  input  logic                 res_en,
  input  logic                 res_mispredict,
  output logic [CW:0]          ckpt_cnt,
  output logic [FW:0]          fl_cnt
);

  // Pointers carry a wrap bit above the index so full and empty are distinguishable.
  function automatic logic [FW:0] flInc(input logic [FW:0] p);
    if (p[FW-1:0] == FW'(FL_D - 1)) return {~p[FW], {FW{1'b0}}};
    return p + 1'b1;
  endfunction

  function automatic logic [FW:0] flCount(input logic [FW:0] h, input logic [FW:0] t);
    if (h[FW] == t[FW]) return t - h;
    return (FW+1)'(FL_D) - {1'b0, h[FW-1:0]} + {1'b0, t[FW-1:0]};
  endfunction

  function automatic logic [CW:0] ckInc(input logic [CW:0] p);
    if (p[CW-1:0] == CW'(NUM_CKPT - 1)) return {~p[CW], {CW{1'b0}}};
    return p + 1'b1;
  endfunction

  function automatic logic [CW:0] ckCount(input logic [CW:0] h, input logic [CW:0] t);
    if (h[CW] == t[CW]) return t - h;
    return (CW+1)'(NUM_CKPT) - {1'b0, h[CW-1:0]} + {1'b0, t[CW-1:0]};
  endfunction

  logic [PW-1:0]        map_q   [NUM_LOG];
  logic [PW-1:0]        map_d   [NUM_LOG];
  logic [NUM_PHYS-1:0]  ready_q;
  logic [ROB_TAG_W-1:0] tag_q   [NUM_PHYS];
  logic [PW-1:0]        fl_q    [FL_D];
  logic [FW:0]          flHead_q, flHead_d, flTail_q;
  logic [PW-1:0]        ckMap_q [NUM_CKPT][NUM_LOG];
  logic [FW:0]          ckHead_q [NUM_CKPT];
  logic [CW:0]          ckRd_q, ckWr_q;

  logic [FW:0]   flCnt;
  logic [CW:0]   ckCnt;
  logic          needsAlloc, recover, resPop, push, fire, alloc;
  logic [PW-1:0] allocPhy;

  assign flCnt      = flCount(flHead_q, flTail_q);
  assign ckCnt      = ckCount(ckRd_q, ckWr_q);
  assign fl_cnt     = flCnt;
  assign ckpt_cnt   = ckCnt;
  assign needsAlloc = uses_rw && (rw_addr != '0);
  assign recover    = res_en && res_mispredict && (ckCnt != '0);
  assign resPop     = res_en && !res_mispredict && (ckCnt != '0);
  assign push       = cmt_en && (cmt_old_phy != '0);
  assign ren_ready  = !(needsAlloc && (flCnt == '0)) &&
                      !(ckpt_take && (ckCnt == (CW+1)'(NUM_CKPT))) && !recover;
  assign fire       = ren_valid && ren_ready;
  assign alloc      = fire && needsAlloc;
  assign allocPhy   = fl_q[flHead_q[FW-1:0]];

  assign rw_phy     = alloc ? allocPhy : '0;
  assign rw_old_phy = map_q[rw_addr];
  assign rs_phy     = map_q[rs_addr];
  assign rt_phy     = map_q[rt_addr];
  assign rs_ready   = (rs_addr == '0) || ready_q[rs_phy] || (wb_en && (wb_phy == rs_phy));
  assign rt_ready   = (rt_addr == '0) || ready_q[rt_phy] || (wb_en && (wb_phy == rt_phy));
  assign rs_tag     = tag_q[rs_phy];
  assign rt_tag     = tag_q[rt_phy];

  // Next map and head: recovery restores the oldest snapshot, otherwise apply this rename.
  always_comb begin
    for (int i = 0; i < NUM_LOG; i++) map_d[i] = map_q[i];
    flHead_d = flHead_q;
    if (recover) begin
      for (int i = 0; i < NUM_LOG; i++) map_d[i] = ckMap_q[ckRd_q[CW-1:0]][i];
      flHead_d = ckHead_q[ckRd_q[CW-1:0]];
    end else if (alloc) begin
      map_d[rw_addr] = allocPhy;
      flHead_d = flInc(flHead_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LOG; i++) map_q[i] <= PW'(i);
      for (int i = 0; i < NUM_PHYS; i++) tag_q[i] <= '0;
      for (int i = 0; i < FL_D; i++) fl_q[i] <= PW'(NUM_LOG + i);
      ready_q  <= '1;
      flHead_q <= '0;
      flTail_q <= {1'b1, {FW{1'b0}}};
      ckRd_q   <= '0;
      ckWr_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_LOG; i++) map_q[i] <= map_d[i];
      flHead_q <= flHead_d;
      if (push) begin
        fl_q[flTail_q[FW-1:0]] <= cmt_old_phy;
        flTail_q <= flInc(flTail_q);
      end
      // Allocation is written after writeback so a same-cycle clash leaves the reg not-ready.
      if (wb_en) ready_q[wb_phy] <= 1'b1;
      if (alloc) begin
        ready_q[allocPhy] <= 1'b0;
        tag_q[allocPhy]   <= ren_rob_tag;
      end
      if (recover) begin
        ckRd_q <= '0;
        ckWr_q <= '0;
      end else begin
        if (resPop) ckRd_q <= ckInc(ckRd_q);
        if (fire && ckpt_take) ckWr_q <= ckInc(ckWr_q);
      end
    end
  end

  // Snapshot storage needs no reset; entries are only read while live.
  always_ff @(posedge clk) begin
    if (!rst && fire && ckpt_take) begin
      for (int i = 0; i < NUM_LOG; i++) ckMap_q[ckWr_q[CW-1:0]][i] <= map_d[i];
      ckHead_q[ckWr_q[CW-1:0]] <= flHead_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && (flCnt == (FW+1)'(FL_D)) && !alloc));
      assert (!(res_en && (ckCnt == '0)));
    end
  end

endmodule

// File: tb/tb_rename_ckpt_unit.sv
// Self-checking bench for rename_ckpt_unit: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_rename_ckpt_unit;
  localparam int NL = 32, NP = 64, NC = 4, FLD = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ren_valid, uses_rw, ckpt_take, wb_en, cmt_en, res_en, res_mispredict;
  logic [4:0] rs_addr, rt_addr, rw_addr;
  logic [3:0] ren_rob_tag;
  logic [5:0] wb_phy, cmt_old_phy;
  logic       ren_ready, rs_ready, rt_ready;
  logic [5:0] rs_phy, rt_phy, rw_phy, rw_old_phy, fl_cnt;
  logic [3:0] rs_tag, rt_tag;
  logic [2:0] ckpt_cnt;

  rename_ckpt_unit dut (
    .clk(clk), .rst(rst), .ren_valid(ren_valid), .ren_ready(ren_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rw_addr(rw_addr), .uses_rw(uses_rw),
    .ren_rob_tag(ren_rob_tag), .ckpt_take(ckpt_take),
    .rs_phy(rs_phy), .rt_phy(rt_phy), .rs_ready(rs_ready), .rt_ready(rt_ready),
    .rs_tag(rs_tag), .rt_tag(rt_tag), .rw_phy(rw_phy), .rw_old_phy(rw_old_phy),
    .wb_en(wb_en), .wb_phy(wb_phy), .cmt_en(cmt_en), .cmt_old_phy(cmt_old_phy),
    .res_en(res_en), .res_mispredict(res_mispredict),
    .ckpt_cnt(ckpt_cnt), .fl_cnt(fl_cnt)
  );

  int nChecks, nFails;

  // Reference model: map/ready/tag arrays, free list as a queue, log of popped regs,
  // and checkpoints as (map snapshot, pop-log length) pairs.
  int              mMap [NL];
  bit              mReady [NP];
  int              mTag [NP];
  int              fl [$];
  int              popLog [$];
  logic [NL*6-1:0] ckMapQ [$];
  int              ckPopQ [$];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NL; i++) mMap[i] = i;
    for (int i = 0; i < NP; i++) begin mReady[i] = 1'b1; mTag[i] = 0; end
    fl.delete(); popLog.delete(); ckMapQ.delete(); ckPopQ.delete();
    for (int i = NL; i < NP; i++) fl.push_back(i);
  endtask

  function automatic logic [NL*6-1:0] packMap();
    logic [NL*6-1:0] v;
    for (int i = 0; i < NL; i++) v[i*6 +: 6] = 6'(mMap[i]);
    return v;
  endfunction

  function automatic bit expSrcReady(input logic [4:0] a);
    int p;
    p = mMap[a];
    return (a == 0) || mReady[p] || (wb_en && (int'(wb_phy) == p));
  endfunction

  function automatic bit expRenReady();
    bit na, rec;
    na  = uses_rw && (rw_addr != 0);
    rec = res_en && res_mispredict && (ckPopQ.size() > 0);
    return !(na && fl.size() == 0) && !(ckpt_take && ckPopQ.size() == NC) && !rec;
  endfunction

  // Wait to mid-cycle and compare every output against the model's current state.
  task automatic checkOutput();
    bit er, rsr, rtr, na;
    @(negedge clk);
    if (!rst) begin
      er  = expRenReady();
      na  = uses_rw && (rw_addr != 0);
      rsr = expSrcReady(rs_addr);
      rtr = expSrcReady(rt_addr);
      checkVal("ren_ready", ren_ready, er);
      checkVal("rs_phy", rs_phy, mMap[rs_addr]);
      checkVal("rt_phy", rt_phy, mMap[rt_addr]);
      checkVal("rs_ready", rs_ready, rsr);
      checkVal("rt_ready", rt_ready, rtr);
      if (!rsr) checkVal("rs_tag", rs_tag, mTag[mMap[rs_addr]]);
      if (!rtr) checkVal("rt_tag", rt_tag, mTag[mMap[rt_addr]]);
      checkVal("rw_phy", rw_phy, (ren_valid && er && na) ? fl[0] : 0);
      checkVal("rw_old_phy", rw_old_phy, mMap[rw_addr]);
      checkVal("fl_cnt", fl_cnt, fl.size());
      checkVal("ckpt_cnt", ckpt_cnt, ckPopQ.size());
    end
  endtask

  // Advance the model by one cycle from the current inputs, then clock the DUT.
  task automatic applyStimulus();
    bit na, rec, rp, fire;
    int p;
    logic [NL*6-1:0] snap;
    if (rst) modelReset();
    else begin
      na   = uses_rw && (rw_addr != 0);
      rec  = res_en && res_mispredict && (ckPopQ.size() > 0);
      rp   = res_en && !res_mispredict && (ckPopQ.size() > 0);
      fire = ren_valid && expRenReady();
      if (wb_en) mReady[wb_phy] = 1'b1;
      if (rp) begin void'(ckMapQ.pop_front()); void'(ckPopQ.pop_front()); end
      if (fire && na) begin
        p = fl.pop_front();
        popLog.push_back(p);
        mMap[rw_addr] = p;
        mReady[p] = 1'b0;
        mTag[p] = ren_rob_tag;
      end
      if (fire && ckpt_take) begin
        ckMapQ.push_back(packMap());
        ckPopQ.push_back(popLog.size());
      end
      if (rec) begin
        snap = ckMapQ[0];
        for (int i = 0; i < NL; i++) mMap[i] = snap[i*6 +: 6];
        while (popLog.size() > ckPopQ[0]) fl.push_front(popLog.pop_back());
        ckMapQ.delete(); ckPopQ.delete();
      end
      if (cmt_en && cmt_old_phy != 0) fl.push_back(cmt_old_phy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ren_valid = 0; uses_rw = 0; ckpt_take = 0; wb_en = 0; cmt_en = 0;
    res_en = 0; res_mispredict = 0; rs_addr = 0; rt_addr = 0; rw_addr = 0;
    ren_rob_tag = 0; wb_phy = 0; cmt_old_phy = 0;
  endtask

  task automatic rename(input int rw, input int tag, input bit take);
    idle();
    ren_valid = 1; uses_rw = 1; rw_addr = 5'(rw); ren_rob_tag = 4'(tag); ckpt_take = take;
  endtask

  // A commit is safe only if a later recovery cannot overfill the free list.
  function automatic bit commitLegal();
    int extra;
    extra = (ckPopQ.size() > 0) ? (popLog.size() - ckPopQ[0]) : 0;
    return (fl.size() + extra) < FLD;
  endfunction

  initial begin
    nChecks = 0; nFails = 0;
    idle(); rst = 1;
    applyStimulus(); applyStimulus();
    rst = 0;

    checkOutput();
    checkVal("reset_fl_cnt", fl_cnt, 32);
    checkVal("reset_ckpt_cnt", ckpt_cnt, 0);
    checkVal("reset_ren_ready", ren_ready, 1);
    applyStimulus();

    rename(5, 1, 0);
    checkOutput();
    checkVal("first_alloc_phy", rw_phy, 32);
    checkVal("first_old_phy", rw_old_phy, 5);
    applyStimulus();

    idle(); ren_valid = 1; rs_addr = 5;
    checkOutput();
    checkVal("dep_rs_phy", rs_phy, 32);
    checkVal("dep_rs_ready", rs_ready, 0);
    checkVal("dep_rs_tag", rs_tag, 1);
    applyStimulus();

    idle(); rs_addr = 5; wb_en = 1; wb_phy = 32;
    checkOutput();
    checkVal("bypass_rs_ready", rs_ready, 1);
    applyStimulus();
    idle(); rs_addr = 5;
    checkOutput();
    checkVal("held_rs_ready", rs_ready, 1);
    applyStimulus();

    rename(3, 2, 1);
    checkOutput(); checkVal("ckpt_alloc_phy", rw_phy, 33); applyStimulus();
    rename(3, 3, 0);
    checkOutput(); checkVal("spec_alloc_r3", rw_phy, 34); applyStimulus();
    rename(7, 4, 0);
    checkOutput(); checkVal("spec_alloc_r7", rw_phy, 35); applyStimulus();
    rename(9, 5, 0); res_en = 1; res_mispredict = 1;
    checkOutput();
    checkVal("recover_blocks", ren_ready, 0);
    checkVal("recover_rw_phy", rw_phy, 0);
    applyStimulus();
    rename(12, 6, 0); rs_addr = 3; rt_addr = 7;
    checkOutput();
    checkVal("restored_map3", rs_phy, 33);
    checkVal("restored_map7", rt_phy, 7);
    checkVal("restored_alloc", rw_phy, 34);
    checkVal("restored_fl_cnt", fl_cnt, 30);
    checkVal("recover_ckpt_cnt", ckpt_cnt, 0);
    applyStimulus();

    for (int k = 0; k < 4; k++) begin
      idle(); ren_valid = 1; ckpt_take = 1;
      checkOutput(); applyStimulus();
    end
    idle(); ren_valid = 1; ckpt_take = 1; res_en = 1;
    checkOutput();
    checkVal("ckpt_full_stall", ren_ready, 0);
    checkVal("ckpt_full_cnt", ckpt_cnt, 4);
    applyStimulus();
    idle(); ckpt_take = 1;
    checkOutput();
    checkVal("ckpt_after_res_cnt", ckpt_cnt, 3);
    checkVal("ckpt_stall_clear", ren_ready, 1);
    applyStimulus();
    for (int k = 0; k < 3; k++) begin
      idle(); res_en = 1; checkOutput(); applyStimulus();
    end

    rename(10, 7, 1);
    checkOutput(); checkVal("ckpt2_alloc", rw_phy, 35); applyStimulus();
    rename(11, 8, 0);
    checkOutput(); checkVal("ckpt2_spec_alloc", rw_phy, 36); applyStimulus();
    idle(); res_en = 1; res_mispredict = 1; cmt_en = 1; cmt_old_phy = 9;
    checkOutput(); applyStimulus();
    idle();
    checkOutput(); checkVal("recover_cmt_fl_cnt", fl_cnt, 29); applyStimulus();
    for (int k = 0; k < 29; k++) begin
      rename(1 + (k % 31), k % 16, 0);
      checkOutput();
      if (k == 28) checkVal("freed_phys9_alloc", rw_phy, 9);
      applyStimulus();
    end

    rename(4, 1, 0);
    checkOutput();
    checkVal("empty_fl_cnt", fl_cnt, 0);
    checkVal("empty_alloc_stall", ren_ready, 0);
    applyStimulus();
    rename(0, 1, 0);
    checkOutput();
    checkVal("empty_rw0_ready", ren_ready, 1);
    checkVal("empty_rw0_phy", rw_phy, 0);
    applyStimulus();
    idle(); cmt_en = 1; cmt_old_phy = 5;
    checkOutput(); applyStimulus();
    rename(4, 2, 0);
    checkOutput();
    checkVal("refill_ready", ren_ready, 1);
    checkVal("refill_alloc", rw_phy, 5);
    applyStimulus();

    for (int c = 0; c < 3000; c++) begin
      idle();
      rst         = ($urandom_range(0, 299) == 0);
      ren_valid   = ($urandom_range(0, 9) < 7);
      uses_rw     = ($urandom_range(0, 3) != 0);
      rs_addr     = 5'($urandom_range(0, 31));
      rt_addr     = 5'($urandom_range(0, 31));
      rw_addr     = 5'($urandom_range(0, 31));
      ren_rob_tag = 4'($urandom_range(0, 15));
      ckpt_take   = ($urandom_range(0, 4) == 0);
      wb_en       = $urandom_range(0, 1);
      wb_phy      = 6'($urandom_range(0, 63));
      if (commitLegal() && $urandom_range(0, 9) < 4) begin
        cmt_en = 1; cmt_old_phy = 6'($urandom_range(0, 63));
      end
      if (ckPopQ.size() > 0 && $urandom_range(0, 4) == 0) begin
        res_en = 1; res_mispredict = ($urandom_range(0, 9) < 3);
      end
      checkOutput();
      applyStimulus();
    end

    idle(); rst = 1; ren_valid = 1; uses_rw = 1; rw_addr = 5;
    applyStimulus();
    idle(); rs_addr = 5;
    checkOutput();
    checkVal("midrst_fl_cnt", fl_cnt, 32);
    checkVal("midrst_ckpt_cnt", ckpt_cnt, 0);
    checkVal("midrst_map5", rs_phy, 5);
    checkVal("midrst_ready", rs_ready, 1);
    applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
